// File: rtl/sprite_animator.sv
// ============================================================================
//  Module   : sprite_animator
//  Purpose  : Parametrised animated sprite renderer with a fixed 3-cycle
//             ROM pipeline and transparency-aware hit output.
//  Option   : SPRITE_MIRROR_EN - adds facing register and left-facing X mirror
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_animator #(
  parameter int SPRITE_W        = 26,
  parameter int SPRITE_H        = 26,
  parameter int NUM_FRAMES      = 3,
  parameter int FRAME_TICKS     = 4,
  parameter int ANCHOR_X        = 15,
  parameter int ANCHOR_Y        = 13,
  parameter int IDX_W           = 6,
  parameter int TRANSPARENT_IDX = 0,
  parameter int ADDR_W          = $clog2(SPRITE_W*NUM_FRAMES*SPRITE_H)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        BallX,
  input  logic [9:0]        BallY,
  input  logic              blank,
  input  logic              left_moving,
  input  logic              right_moving,
  input  logic              frame_tick,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic              sprite_hit,
  output logic [IDX_W-1:0]  sprite_index
);

  localparam int c_FRAME_W    = (NUM_FRAMES  > 1) ? $clog2(NUM_FRAMES)  : 1;
  localparam int c_TICK_W     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int c_ROW_STRIDE = SPRITE_W * NUM_FRAMES;

  logic [9:0]           r_pos_x;
  logic [9:0]           r_pos_y;
  logic [c_FRAME_W-1:0] r_frame;
  logic [c_TICK_W-1:0]  r_tick_cnt;

  logic [ADDR_W-1:0]    r_rom_addr;
  logic                 r_inbox_d1;
  logic                 r_blank_d1;
  logic                 r_inbox_d2;
  logic                 r_blank_d2;
  logic                 r_hit;
  logic [IDX_W-1:0]     r_index;

  logic                 w_moving;
  logic [10:0]          w_rx;
  logic [10:0]          w_ry;
  logic                 w_inbox;
  logic [9:0]           w_xm;
  logic [ADDR_W-1:0]    w_addr;
  logic                 w_opaque;

  assign w_moving = left_moving ^ right_moving;

  // Position and animation state only change on the per-video-frame tick
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pos_x    <= '0;
      r_pos_y    <= '0;
      r_frame    <= '0;
      r_tick_cnt <= '0;
    end else if (frame_tick) begin
      r_pos_x <= BallX;
      r_pos_y <= BallY;
      if (w_moving) begin
        if (r_tick_cnt == c_TICK_W'(FRAME_TICKS-1)) begin
          r_tick_cnt <= '0;
          r_frame    <= (r_frame == c_FRAME_W'(NUM_FRAMES-1)) ? '0 : r_frame + 1'b1;
        end else begin
          r_tick_cnt <= r_tick_cnt + 1'b1;
        end
      end else begin
        r_frame    <= '0;
        r_tick_cnt <= '0;
      end
    end
  end

  // 11-bit arithmetic lets a sprite hang off the left/top edge of the screen
  assign w_rx    = 11'(DrawX) - 11'(r_pos_x) + 11'(ANCHOR_X);
  assign w_ry    = 11'(DrawY) - 11'(r_pos_y) + 11'(ANCHOR_Y);
  assign w_inbox = !w_rx[10] && (w_rx[9:0] < 10'(SPRITE_W)) &&
                   !w_ry[10] && (w_ry[9:0] < 10'(SPRITE_H));

`ifdef SPRITE_MIRROR_EN
  typedef enum logic {
    FACE_RIGHT = 1'b0,
    FACE_LEFT  = 1'b1
  } facing_t;

  facing_t r_facing;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_facing <= FACE_RIGHT;
    end else if (frame_tick && w_moving) begin
      r_facing <= left_moving ? FACE_LEFT : FACE_RIGHT;
    end
  end

  assign w_xm = (r_facing == FACE_LEFT) ? (10'(SPRITE_W-1) - w_rx[9:0]) : w_rx[9:0];
`else
  assign w_xm = w_rx[9:0];
`endif

  assign w_addr = ADDR_W'(w_ry[9:0]) * ADDR_W'(c_ROW_STRIDE)
                + ADDR_W'(r_frame)   * ADDR_W'(SPRITE_W)
                + ADDR_W'(w_xm);

  assign w_opaque = (rom_q != IDX_W'(TRANSPARENT_IDX));

  // inbox/blank ride two stages so they line up with the ROM data
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_addr <= '0;
      r_inbox_d1 <= 1'b0;
      r_blank_d1 <= 1'b0;
      r_inbox_d2 <= 1'b0;
      r_blank_d2 <= 1'b0;
      r_hit      <= 1'b0;
      r_index    <= '0;
    end else begin
      r_rom_addr <= w_inbox ? w_addr : '0;
      r_inbox_d1 <= w_inbox;
      r_blank_d1 <= blank;
      r_inbox_d2 <= r_inbox_d1;
      r_blank_d2 <= r_blank_d1;
      r_hit      <= r_inbox_d2 & r_blank_d2 & w_opaque;
      r_index    <= (r_inbox_d2 & r_blank_d2 & w_opaque) ? rom_q : '0;
    end
  end

  assign rom_addr     = r_rom_addr;
  assign sprite_hit   = r_hit;
  assign sprite_index = r_index;

endmodule

`default_nettype wire

// File: tb/tb_sprite_animator.sv
// ============================================================================
//  Module   : tb_sprite_animator
//  Purpose  : Directed self-checking bench for sprite_animator (default
//             parameters; SPRITE_MIRROR_EN selects mirrored expectations).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_animator;

  logic        vga_clk;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY, BallX, BallY;
  logic        blank, left_moving, right_moving, frame_tick;
  logic [10:0] rom_addr;
  logic [5:0]  rom_q;
  logic        sprite_hit;
  logic [5:0]  sprite_index;

  logic [5:0]  rom_val;
  int          n_vec;
  int          n_bad;

  sprite_animator dut (
    .vga_clk      (vga_clk),
    .reset_n      (reset_n),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .BallX        (BallX),
    .BallY        (BallY),
    .blank        (blank),
    .left_moving  (left_moving),
    .right_moving (right_moving),
    .frame_tick   (frame_tick),
    .rom_addr     (rom_addr),
    .rom_q        (rom_q),
    .sprite_hit   (sprite_hit),
    .sprite_index (sprite_index)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Synchronous ROM stand-in: returns rom_val one cycle after any address
  always @(posedge vga_clk) rom_q <= rom_val;

  task automatic do_tick(input logic l, input logic r);
    @(negedge vga_clk);
    left_moving  = l;
    right_moving = r;
    frame_tick   = 1'b1;
    @(negedge vga_clk);
    frame_tick   = 1'b0;
  endtask

  // Drive a pixel and stop just after the edge that registers rom_addr
  task automatic present(input logic [9:0] dx, input logic [9:0] dy, input logic blk);
    @(negedge vga_clk);
    DrawX = dx;
    DrawY = dy;
    blank = blk;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic settle2;
    @(posedge vga_clk);
    @(posedge vga_clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    DrawX = 10'($urandom); DrawY = 10'($urandom);
    BallX = 10'($urandom); BallY = 10'($urandom);
    blank = 1'b1; left_moving = 1'($urandom); right_moving = 1'($urandom);
    frame_tick = 1'b1; rom_val = 6'd9;
    repeat (3) @(posedge vga_clk);
    #1;
    n_vec++; if (rom_addr !== 11'd0) begin n_bad++; $display("FAIL reset_addr got=%0d exp=0", rom_addr); end
    n_vec++; if (sprite_hit !== 1'b0) begin n_bad++; $display("FAIL reset_hit got=%0b exp=0", sprite_hit); end
    n_vec++; if (sprite_index !== 6'd0) begin n_bad++; $display("FAIL reset_idx got=%0d exp=0", sprite_index); end
    @(negedge vga_clk);
    frame_tick = 1'b0; left_moving = 1'b0; right_moving = 1'b0; rom_val = 6'd0;
    reset_n = 1'b1;
    // pos 0, frame 0, facing RIGHT: rx=15, ry=13 -> 13*78+15
    present(10'd0, 10'd0, 1'b0);
    n_vec++; if (rom_addr !== 11'd1029) begin n_bad++; $display("FAIL post_reset_addr got=%0d exp=1029", rom_addr); end
  endtask

  task automatic test_animation;
    BallX = 10'd100; BallY = 10'd100;
    for (int t = 1; t <= 12; t++) begin
      do_tick(1'b0, 1'b1);
      if (t == 3 || t == 4 || t == 8 || t == 12) begin
        present(10'd85, 10'd87, 1'b0);
        n_vec++;
        if (rom_addr !== 11'((t / 4) % 3 * 26)) begin
          n_bad++;
          $display("FAIL anim_tick%0d got=%0d exp=%0d", t, rom_addr, (t / 4) % 3 * 26);
        end
      end
    end
    repeat (5) do_tick(1'b0, 1'b1);
    present(10'd85, 10'd87, 1'b0);
    n_vec++; if (rom_addr !== 11'd26) begin n_bad++; $display("FAIL anim_tick17 got=%0d exp=26", rom_addr); end
    do_tick(1'b0, 1'b0);
    present(10'd85, 10'd87, 1'b0);
    n_vec++; if (rom_addr !== 11'd0) begin n_bad++; $display("FAIL anim_stop got=%0d exp=0", rom_addr); end
  endtask

  task automatic test_address;
    repeat (4) do_tick(1'b0, 1'b1);
    rom_val = 6'd5;
    present(10'd110, 10'd90, 1'b1);
    n_vec++; if (rom_addr !== 11'd285) begin n_bad++; $display("FAIL addr_285 got=%0d exp=285", rom_addr); end
    present(10'd84, 10'd90, 1'b1);
    n_vec++; if (rom_addr !== 11'd0) begin n_bad++; $display("FAIL addr_outbox got=%0d exp=0", rom_addr); end
    settle2;
    n_vec++; if (sprite_hit !== 1'b0) begin n_bad++; $display("FAIL hit_outbox got=%0b exp=0", sprite_hit); end
  endtask

  task automatic test_facing;
    logic [10:0] exp_a;
    do_tick(1'b1, 1'b0);
    do_tick(1'b1, 1'b1);
`ifdef SPRITE_MIRROR_EN
    exp_a = 11'd25;
`else
    exp_a = 11'd0;
`endif
    present(10'd85, 10'd87, 1'b0);
    n_vec++; if (rom_addr !== exp_a) begin n_bad++; $display("FAIL face_hold got=%0d exp=%0d", rom_addr, exp_a); end
    repeat (4) do_tick(1'b1, 1'b0);
`ifdef SPRITE_MIRROR_EN
    exp_a = 11'd51;
`else
    exp_a = 11'd26;
`endif
    present(10'd85, 10'd87, 1'b0);
    n_vec++; if (rom_addr !== exp_a) begin n_bad++; $display("FAIL face_left_anim got=%0d exp=%0d", rom_addr, exp_a); end
    do_tick(1'b0, 1'b1);
    do_tick(1'b0, 1'b0);
    present(10'd85, 10'd87, 1'b0);
    n_vec++; if (rom_addr !== 11'd0) begin n_bad++; $display("FAIL face_right got=%0d exp=0", rom_addr); end
  endtask

  task automatic test_edge_anchor;
    BallX = 10'd5; BallY = 10'd5;
    do_tick(1'b0, 1'b0);
    present(10'd0, 10'd0, 1'b0);
    n_vec++; if (rom_addr !== 11'd634) begin n_bad++; $display("FAIL anchor_634 got=%0d exp=634", rom_addr); end
  endtask

  task automatic test_hit;
    rom_val = 6'd5;
    present(10'd0, 10'd0, 1'b1);
    settle2;
    n_vec++; if (sprite_hit !== 1'b1) begin n_bad++; $display("FAIL hit_opaque got=%0b exp=1", sprite_hit); end
    n_vec++; if (sprite_index !== 6'd5) begin n_bad++; $display("FAIL idx_opaque got=%0d exp=5", sprite_index); end
    rom_val = 6'd0;
    present(10'd0, 10'd0, 1'b1);
    settle2;
    n_vec++; if (sprite_hit !== 1'b0) begin n_bad++; $display("FAIL hit_transp got=%0b exp=0", sprite_hit); end
    rom_val = 6'd5;
    present(10'd0, 10'd0, 1'b0);
    settle2;
    n_vec++; if (sprite_hit !== 1'b0) begin n_bad++; $display("FAIL hit_blank got=%0b exp=0", sprite_hit); end
    n_vec++; if (sprite_index !== 6'd0) begin n_bad++; $display("FAIL idx_blank got=%0d exp=0", sprite_index); end
  endtask

  task automatic test_reset_midstream;
    BallX = 10'd0; BallY = 10'd0;
    do_tick(1'b0, 1'b0);
    rom_val = 6'd7;
    present(10'd0, 10'd0, 1'b1);
    settle2;
    n_vec++; if (sprite_hit !== 1'b1) begin n_bad++; $display("FAIL mid_prehit got=%0b exp=1", sprite_hit); end
    @(negedge vga_clk);
    reset_n = 1'b0;
    #1;
    n_vec++; if (sprite_hit !== 1'b0 || sprite_index !== 6'd0) begin
      n_bad++; $display("FAIL mid_async got=%0b/%0d exp=0/0", sprite_hit, sprite_index);
    end
    @(negedge vga_clk);
    reset_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge vga_clk);
      #1;
      n_vec++;
      if (sprite_hit !== (c == 3)) begin
        n_bad++; $display("FAIL mid_resume_c%0d got=%0b exp=%0b", c, sprite_hit, (c == 3));
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset;
    test_animation;
    test_address;
    test_facing;
    test_edge_anchor;
    test_hit;
    test_reset_midstream;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
